// File: rtl/spi_regbank_pkg.sv
// Shared defaults and helpers for the SPI register-bank slave.
package spi_regbank_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_AW    = 8;
    localparam int DEF_NREGS = 16;

    localparam int   SYNC_DEPTH = 2;
    localparam logic IDLE_CS    = 1'b1;
    localparam logic IDLE_SCK   = 1'b0;
    localparam logic IDLE_SDO   = 1'b0;

    // Width needed to count/index n items; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_regbank_slave_sync.sv
// spi_sync_edge: two-flop synchroniser plus one history flop for edge detection.
module spi_sync_edge
    import spi_regbank_pkg::*;
#(
    parameter logic IDLE = 1'b0
) (
    input  logic fclk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH:0] sr;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {(SYNC_DEPTH + 1){IDLE}};
        end else begin
            sr <= {sr[SYNC_DEPTH-1:0], din};
        end
    end

    assign level = sr[SYNC_DEPTH-1];
    assign rise  = sr[SYNC_DEPTH-1] & ~sr[SYNC_DEPTH];
    assign fall  = ~sr[SYNC_DEPTH-1] & sr[SYNC_DEPTH];

endmodule

// File: rtl/spi_regbank_slave.sv
// Oversampled mode-0 SPI slave with an internal register bank and external pass-through port.
// Define SPI_REGBANK_AUTOINC_EN to advance reg_addr after every data word (burst access).
module spi_regbank_slave
    import spi_regbank_pkg::*;
#(
    parameter int             DW      = DEF_DW,
    parameter int             AW      = DEF_AW,
    parameter int             NREGS   = DEF_NREGS,
    parameter logic [DW-1:0]  RST_VAL = '0
) (
    input  logic                fclk,
    input  logic                rst_n,
    input  logic                spics_n,
    input  logic                spick,
    input  logic                spido,
    output logic                spidi,
    input  logic [DW-1:0]       status_in,
    output logic [NREGS*DW-1:0] regs_q,
    output logic [AW-1:0]       reg_addr,
    output logic [DW-1:0]       wr_data,
    output logic                wr_stb,
    input  logic [DW-1:0]       rd_data_ext,
    output logic                rd_stb,
    output logic                frame_end
);

    localparam int            BW      = cnt_w(DW);
    localparam int            IW      = cnt_w(NREGS);
    localparam logic [BW-1:0] LAST    = BW'(DW - 1);
    localparam logic [AW:0]   NREGS_W = (AW + 1)'(NREGS);

    logic scs_n, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic sdo, sdo_rise, sdo_fall;

    spi_sync_edge #(.IDLE(IDLE_CS))  u_sync_cs  (.fclk(fclk), .rst_n(rst_n), .din(spics_n),
                                                 .level(scs_n), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.IDLE(IDLE_SCK)) u_sync_sck (.fclk(fclk), .rst_n(rst_n), .din(spick),
                                                 .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
    spi_sync_edge #(.IDLE(IDLE_SDO)) u_sync_sdo (.fclk(fclk), .rst_n(rst_n), .din(spido),
                                                 .level(sdo), .rise(sdo_rise), .fall(sdo_fall));

    logic unused_edges;
    assign unused_edges = ^{sck_lvl, sck_fall, sdo_rise, sdo_fall};

    logic [DW-1:0] regs [NREGS];
    logic [AW-1:0] addr_sr;
    logic [AW-1:0] next_addr;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] shift_in;
    logic [DW-1:0] shift_out;
    logic [DW-1:0] word_in;
    logic          got_word;

    function automatic logic in_bank(input logic [AW-1:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    function automatic logic [DW-1:0] readback(input logic [AW-1:0] a);
        if (in_bank(a)) return regs[a[IW-1:0]];
        else            return rd_data_ext;
    endfunction

    assign word_in = {sdo, shift_in[DW-1:1]};
    assign spidi   = shift_out[0];

`ifdef SPI_REGBANK_AUTOINC_EN
    assign next_addr = reg_addr + AW'(1);
`else
    assign next_addr = reg_addr;
`endif

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_q[g*DW +: DW] = regs[g];
    end

    // Internal write lands on the cycle wr_stb is high, regardless of CS activity.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= RST_VAL;
        end else if (wr_stb && in_bank(reg_addr)) begin
            regs[reg_addr[IW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_sr   <= '0;
            reg_addr  <= '0;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            wr_data   <= '0;
            wr_stb    <= 1'b0;
            rd_stb    <= 1'b0;
            frame_end <= 1'b0;
            got_word  <= 1'b0;
        end else begin
            wr_stb    <= 1'b0;
            rd_stb    <= 1'b0;
            frame_end <= 1'b0;
            if (cs_fall) begin
                reg_addr  <= addr_sr;
                bit_cnt   <= '0;
                shift_out <= readback(addr_sr);
                rd_stb    <= 1'b1;
                got_word  <= 1'b0;
            end else if (cs_rise) begin
                // Any partially shifted word is dropped here.
                shift_out <= status_in;
                addr_sr   <= '0;
                bit_cnt   <= '0;
                frame_end <= got_word;
                got_word  <= 1'b0;
            end else begin
                if (wr_stb) begin
                    reg_addr  <= next_addr;
                    shift_out <= readback(next_addr);
                    rd_stb    <= 1'b1;
                end
                if (sck_rise) begin
                    shift_out <= {1'b0, shift_out[DW-1:1]};
                    if (scs_n) begin
                        addr_sr <= {sdo, addr_sr[AW-1:1]};
                    end else begin
                        shift_in <= word_in;
                        if (bit_cnt == LAST) begin
                            bit_cnt  <= '0;
                            wr_data  <= word_in;
                            wr_stb   <= 1'b1;
                            got_word <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench for spi_regbank_slave; expectations follow SPI_REGBANK_AUTOINC_EN when defined.
module tb_spi_regbank_slave;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int NREGS = 16;

    logic                fclk = 1'b0;
    logic                rst_n;
    logic                spics_n;
    logic                spick;
    logic                spido;
    logic                spidi;
    logic [DW-1:0]       status_in;
    logic [NREGS*DW-1:0] regs_q;
    logic [AW-1:0]       reg_addr;
    logic [DW-1:0]       wr_data;
    logic                wr_stb;
    logic [DW-1:0]       rd_data_ext;
    logic                rd_stb;
    logic                frame_end;

    spi_regbank_slave #(.DW(DW), .AW(AW), .NREGS(NREGS), .RST_VAL('0)) dut (
        .fclk(fclk), .rst_n(rst_n), .spics_n(spics_n), .spick(spick), .spido(spido),
        .spidi(spidi), .status_in(status_in), .regs_q(regs_q), .reg_addr(reg_addr),
        .wr_data(wr_data), .wr_stb(wr_stb), .rd_data_ext(rd_data_ext), .rd_stb(rd_stb),
        .frame_end(frame_end)
    );

    always #5 fclk = ~fclk;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] last_wr_addr = '0;
    logic [7:0] last_wr_data = '0;

    always @(posedge fclk) begin
        if (wr_stb) begin
            wr_cnt++;
            last_wr_addr = reg_addr;
            last_wr_data = wr_data;
        end
        if (rd_stb) rd_cnt++;
        if (frame_end) fe_cnt++;
    end

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [127:0] exp_regs;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge fclk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spido = b;
        cyc(4);
        r = spidi;
        spick = 1'b1;
        cyc(4);
        spick = 1'b0;
    endtask

    task automatic spi_word(input logic [7:0] w, output logic [7:0] r);
        logic b;
        for (int i = 0; i < 8; i++) begin
            spi_bit(w[i], b);
            r[i] = b;
        end
    endtask

    task automatic open_frame(input logic [7:0] a, output logic [7:0] st);
        cyc(2);
        spi_word(a, st);
        spics_n = 1'b0;
        cyc(4);
    endtask

    task automatic close_frame();
        spics_n = 1'b1;
        cyc(6);
    endtask

    logic [7:0] st, r1, r2, r3;
    int         wr0, rd0, fe0;

    initial begin
        rst_n       = 1'b0;
        spics_n     = 1'b1;
        spick       = 1'b0;
        spido       = 1'b0;
        status_in   = 8'h5C;
        rd_data_ext = 8'hE7;
        exp_regs    = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        check("rst_regs",     128'(regs_q),    exp_regs);
        check("rst_reg_addr", 128'(reg_addr),  128'(0));
        check("rst_wr_data",  128'(wr_data),   128'(0));
        check("rst_spidi",    128'(spidi),     128'(0));
        check("rst_strobes",  128'({wr_stb, rd_stb, frame_end}), 128'(0));

        // Empty frame: loads status into the shifter, no frame_end.
        rd0 = rd_cnt; fe0 = fe_cnt;
        spics_n = 1'b0; cyc(6);
        close_frame();
        check("empty_rd_stb",    128'(rd_cnt - rd0), 128'(1));
        check("empty_frame_end", 128'(fe_cnt - fe0), 128'(0));

        // Single write to reg 3.
        wr0 = wr_cnt; rd0 = rd_cnt; fe0 = fe_cnt;
        open_frame(8'h03, st);
        check("status_out", 128'(st), 128'(8'h5C));
        spi_word(8'hA5, r1);
        close_frame();
        exp_regs[3*8 +: 8] = 8'hA5;
        check("wr_regs",      128'(regs_q),        exp_regs);
        check("wr_cnt",       128'(wr_cnt - wr0),  128'(1));
        check("wr_addr",      128'(last_wr_addr),  128'(8'h03));
        check("wr_data",      128'(last_wr_data),  128'(8'hA5));
        check("wr_frame_end", 128'(fe_cnt - fe0),  128'(1));
        check("wr_rd_stb",    128'(rd_cnt - rd0),  128'(2));
`ifdef SPI_REGBANK_AUTOINC_EN
        check("wr_reg_addr",  128'(reg_addr), 128'(8'h04));
`else
        check("wr_reg_addr",  128'(reg_addr), 128'(8'h03));
`endif

        // Preload reg 5 and reg 6 in separate frames.
        open_frame(8'h05, st); spi_word(8'h3C, r1); close_frame();
        open_frame(8'h06, st); spi_word(8'h6B, r1); close_frame();
        exp_regs[5*8 +: 8] = 8'h3C;
        exp_regs[6*8 +: 8] = 8'h6B;
        check("preload_regs", 128'(regs_q), exp_regs);

        // Readback from reg 5; resend the same data so contents are preserved.
        rd0 = rd_cnt;
        open_frame(8'h05, st);
        check("rb_rd_stb_csfall", 128'(rd_cnt - rd0), 128'(1));
        spi_word(8'h3C, r1);
        check("rb_word0", 128'(r1), 128'(8'h3C));
`ifdef SPI_REGBANK_AUTOINC_EN
        spi_word(8'h6B, r2);
        check("rb_word1", 128'(r2), 128'(8'h6B));
`else
        spi_word(8'h3C, r2);
        check("rb_word1", 128'(r2), 128'(8'h3C));
`endif
        close_frame();
        check("rb_regs", 128'(regs_q), exp_regs);

        // Partial word: 5 bits then CS rise.
        wr0 = wr_cnt; fe0 = fe_cnt;
        open_frame(8'h07, st);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r1[0]);
        close_frame();
        check("part_wr_cnt",    128'(wr_cnt - wr0), 128'(0));
        check("part_frame_end", 128'(fe_cnt - fe0), 128'(0));
        check("part_regs",      128'(regs_q),       exp_regs);

        // Burst starting at 0x0E.
        wr0 = wr_cnt;
        open_frame(8'h0E, st);
        spi_word(8'h11, r1);
        spi_word(8'h22, r2);
        spi_word(8'h33, r3);
        close_frame();
        check("burst_wr_cnt",  128'(wr_cnt - wr0), 128'(3));
        check("burst_wr_data", 128'(last_wr_data), 128'(8'h33));
`ifdef SPI_REGBANK_AUTOINC_EN
        exp_regs[14*8 +: 8] = 8'h11;
        exp_regs[15*8 +: 8] = 8'h22;
        check("burst_wr_addr", 128'(last_wr_addr), 128'(8'h10));
        check("burst_rd_ext",  128'(r3),           128'(8'hE7));
`else
        exp_regs[14*8 +: 8] = 8'h33;
        check("burst_wr_addr", 128'(last_wr_addr), 128'(8'h0E));
        check("burst_rd_same", 128'(r3),           128'(8'h11));
`endif
        check("burst_regs", 128'(regs_q), exp_regs);

        // Address wrap from 0xFF.
        wr0 = wr_cnt;
        open_frame(8'hFF, st);
        spi_word(8'h77, r1);
        check("wrap_rd_ext", 128'(r1), 128'(8'hE7));
        spi_word(8'h88, r2);
        close_frame();
        check("wrap_wr_cnt", 128'(wr_cnt - wr0), 128'(2));
`ifdef SPI_REGBANK_AUTOINC_EN
        exp_regs[0 +: 8] = 8'h88;
        check("wrap_wr_addr", 128'(last_wr_addr), 128'(8'h00));
`else
        check("wrap_wr_addr", 128'(last_wr_addr), 128'(8'hFF));
`endif
        check("wrap_regs", 128'(regs_q), exp_regs);

        // Reset in the middle of a data word.
        open_frame(8'h02, st);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, r1[0]);
        rst_n = 1'b0;
        cyc(2);
        exp_regs = '0;
        check("mid_rst_regs",     128'(regs_q),   exp_regs);
        check("mid_rst_reg_addr", 128'(reg_addr), 128'(0));
        check("mid_rst_wr_data",  128'(wr_data),  128'(0));
        check("mid_rst_spidi",    128'(spidi),    128'(0));
        check("mid_rst_strobes",  128'({wr_stb, rd_stb, frame_end}), 128'(0));
        spics_n = 1'b1;
        spick   = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(4);

        // Normal frame after reset.
        wr0 = wr_cnt; fe0 = fe_cnt;
        open_frame(8'h01, st);
        check("post_rst_status", 128'(st), 128'(0));
        spi_word(8'h5A, r1);
        close_frame();
        exp_regs[1*8 +: 8] = 8'h5A;
        check("post_rst_regs",      128'(regs_q),       exp_regs);
        check("post_rst_wr_cnt",    128'(wr_cnt - wr0), 128'(1));
        check("post_rst_frame_end", 128'(fe_cnt - fe0), 128'(1));
        check("post_rst_wr_addr",   128'(last_wr_addr), 128'(8'h01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
